// File: rtl/rpm_pkg.sv
// -----------------------------------------------------------------------------
// rpm_pkg
// Shared constants, state encoding and helpers for the radix-4 Russian-peasant
// unsigned multiplier (russian_peasant_modified_umul_8).
//   RPM_WIDTH   operand width (default build)
//   RPM_PWIDTH  product width, 2*RPM_WIDTH
//   RPM_ITER    radix-4 iterations for a full operand, RPM_WIDTH/2
//   RPM_CNT_W   iteration counter width
// -----------------------------------------------------------------------------
package rpm_pkg;

   localparam int RPM_WIDTH  = 8;
   localparam int RPM_PWIDTH = 2 * RPM_WIDTH;
   localparam int RPM_ITER   = RPM_WIDTH / 2;

   // Counter must hold 0..iter-1; a single iteration still needs one bit.
   function automatic int rpm_cnt_width(input int iter);
      return (iter > 1) ? $clog2(iter) : 1;
   endfunction

   localparam int RPM_CNT_W = rpm_cnt_width(RPM_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } rpm_state_t;

endpackage : rpm_pkg

// File: rtl/rpm_radix4_pp.sv
// -----------------------------------------------------------------------------
// rpm_radix4_pp
// Combinational radix-4 partial-product selector: pp = digit * mcand for a
// 2-bit multiplier digit, i.e. one of 0, A, 2A, 3A. 3A is built with a shift
// and an add, so no multiplier primitive is inferred.
// Ports:
//   mcand  in   PWIDTH  shifted multiplicand (already zero-extended)
//   digit  in   2       current multiplier digit
//   pp     out  PWIDTH  selected partial product
// -----------------------------------------------------------------------------
module rpm_radix4_pp
   import rpm_pkg::*;
#(
   parameter int PWIDTH = RPM_PWIDTH
) (
   input  logic [PWIDTH-1:0] mcand,
   input  logic [1:0]        digit,
   output logic [PWIDTH-1:0] pp
);

   logic [PWIDTH-1:0] mcand_x2;
   logic [PWIDTH-1:0] mcand_x3;

   assign mcand_x2 = mcand << 1;
   assign mcand_x3 = mcand + mcand_x2;

   always_comb begin
      unique case (digit)
         2'd0:    pp = '0;
         2'd1:    pp = mcand;
         2'd2:    pp = mcand_x2;
         default: pp = mcand_x3;
      endcase
   end

endmodule : rpm_radix4_pp

// File: rtl/russian_peasant_modified_umul_8.sv
// -----------------------------------------------------------------------------
// russian_peasant_modified_umul_8
// Sequential WIDTH x WIDTH unsigned multiplier, radix-4 Russian-peasant scheme.
// Every RUN cycle retires two multiplier bits: acc += {0,A,2A,3A}[mplr[1:0]],
// then the multiplicand shifts left by 2 and the multiplier right by 2.
// Handshake: start accepted in IDLE or DONE, busy high in RUN, done is a
// one-cycle pulse with product valid on and after it.
//
// Configuration macro RPM_EARLY_TERM_EN:
//   defined   -> leave RUN after the iteration in which the multiplier becomes
//                zero (at least one iteration); latency 1..WIDTH/2 cycles.
//   undefined -> always WIDTH/2 iterations.
//   The product is identical in both builds.
//
// Ports:
//   clk      in   1        clock, rising edge
//   rst      in   1        synchronous active-high reset, priority over start
//   start    in   1        operation request
//   A        in   WIDTH    multiplicand, captured on accept
//   B        in   WIDTH    multiplier, captured on accept
//   product  out  2*WIDTH  registered result, held until the next accept
//   busy     out  1        high while in RUN
//   done     out  1        one-cycle completion pulse
// -----------------------------------------------------------------------------
module russian_peasant_modified_umul_8
   import rpm_pkg::*;
#(
   parameter int WIDTH = RPM_WIDTH   // must be even and >= 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 done
);

   localparam int PW    = 2 * WIDTH;
   localparam int ITER  = WIDTH / 2;
   localparam int CNT_W = rpm_cnt_width(ITER);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   rpm_state_t        state_q,   state_d;
   logic [PW-1:0]     mcand_q,   mcand_d;
   logic [WIDTH-1:0]  mplr_q,    mplr_d;
   logic [PW-1:0]     acc_q,     acc_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [PW-1:0]     product_q, product_d;

   logic [PW-1:0]     pp;
   logic [PW-1:0]     acc_sum;
   logic [WIDTH-1:0]  mplr_shift;
   logic              last_iter;

   rpm_radix4_pp #(
      .PWIDTH (PW)
   ) u_pp (
      .mcand (mcand_q),
      .digit (mplr_q[1:0]),
      .pp    (pp)
   );

   // Full 2*WIDTH-bit add; the running sum never exceeds A*B, so no carry-out.
   assign acc_sum    = acc_q + pp;
   assign mplr_shift = mplr_q >> 2;

`ifdef RPM_EARLY_TERM_EN
   // Stop once no multiplier bits remain; the counter still caps the run.
   assign last_iter = (cnt_q == LAST_CNT) || (mplr_shift == '0);
`else
   assign last_iter = (cnt_q == LAST_CNT);
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = {{WIDTH{1'b0}}, A};
               mplr_d  = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            // start is deliberately ignored here; operands stay as captured.
            acc_d   = acc_sum;
            mcand_d = mcand_q << 2;
            mplr_d  = mplr_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_iter) begin
               product_d = acc_sum;
               state_d   = DONE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order. All registers are
   // cleared by the synchronous reset, including the datapath, so an aborted
   // operation leaves nothing stale behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // DONE always lasts exactly one cycle, so decoding it gives the done pulse.
   assign product = product_q;
   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule : russian_peasant_modified_umul_8

// File: tb/tb_russian_peasant_modified_umul_8.sv
// -----------------------------------------------------------------------------
// tb_russian_peasant_modified_umul_8
// Directed self-checking bench for russian_peasant_modified_umul_8 (WIDTH=8).
// Expected latency depends on RPM_EARLY_TERM_EN, matching the DUT build.
// -----------------------------------------------------------------------------
module tb_russian_peasant_modified_umul_8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] product;
   logic        busy;
   logic        done;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] last_prod;

   always #5 clk = ~clk;

   russian_peasant_modified_umul_8 dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .product (product),
      .busy    (busy),
      .done    (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Cycles from accept edge to the edge that raises done.
   function automatic int exp_lat(input logic [7:0] b);
`ifdef RPM_EARLY_TERM_EN
      int          n;
      logic [7:0]  x;
      n = 1;
      x = b >> 2;
      while (x != 8'd0) begin
         n++;
         x = x >> 2;
      end
      return n;
`else
      return 4;
`endif
   endfunction

   // Called at a negedge; drives start so the next posedge accepts it, then
   // waits (bounded) for done. Leaves the caller at the negedge where done=1.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit meddle);
      int    n;
      int    busy_n;
      string tag;
      tag   = $sformatf("%0dx%0d", a, b);
      A     = a;
      B     = b;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      n      = 0;
      busy_n = 0;
      while (!done && n < 20) begin
         if (busy) busy_n++;
         if (n == 0) check({tag, " held"}, product, last_prod);
         if (meddle && n == 0) begin
            start = 1'b1;
            A     = 8'd7;
            B     = 8'd9;
         end
         if (meddle && n == 2) start = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, " latency"}, n, exp_lat(b));
      check({tag, " busy_cycles"}, busy_n, exp_lat(b));
      check({tag, " product"}, product, exp);
      check({tag, " busy_at_done"}, busy, 1'b0);
      last_prod = exp;
   endtask

   initial begin
      int          done_seen;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rexp;

      // Reset for two cycles with start asserted: start must be ignored.
      rst   = 1'b1;
      start = 1'b1;
      A     = 8'd5;
      B     = 8'd5;
      repeat (2) @(negedge clk);
      check("reset product", product, 16'd0);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_reset busy", busy, 1'b0);
      check("post_reset done", done, 1'b0);
      last_prod = 16'd0;

      // Basic operation, then done must drop after one cycle.
      do_op(8'd98, 8'd115, 16'd11270, 1'b0);
      @(negedge clk);
      check("done pulse width", done, 1'b0);
      check("idle busy", busy, 1'b0);
      check("idle product held", product, 16'd11270);

      // Back-to-back: second start issued in the DONE cycle.
      do_op(8'd170, 8'd99, 16'd16830, 1'b0);
      do_op(8'd229, 8'd42, 16'd9618, 1'b0);
      @(negedge clk);

      // Corners.
      do_op(8'd0,   8'd85,  16'd0,     1'b0);
      do_op(8'd85,  8'd0,   16'd0,     1'b0);
      do_op(8'd255, 8'd255, 16'd65025, 1'b0);
      do_op(8'd255, 8'd1,   16'd255,   1'b0);
      do_op(8'd1,   8'd128, 16'd128,   1'b0);
      @(negedge clk);

      // start with new operands during RUN must be ignored.
      do_op(8'd98, 8'd115, 16'd11270, 1'b1);
      @(negedge clk);
      check("meddle idle busy", busy, 1'b0);

      // Reset in the middle of RUN: back to IDLE, no done pulse.
      A     = 8'd200;
      B     = 8'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("midrun busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", busy, 1'b0);
      check("abort done", done, 1'b0);
      check("abort product", product, 16'd0);
      done_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort no done", done_seen, 0);
      last_prod = 16'd0;

      // Latency-sensitive vectors (short under early termination).
      do_op(8'd17,  8'd3,   16'd51,    1'b0);
      do_op(8'd200, 8'd200, 16'd40000, 1'b0);
      do_op(8'd123, 8'd0,   16'd0,     1'b0);
      do_op(8'd11,  8'd5,   16'd55,    1'b0);

      // Random operands against the arithmetic product.
      repeat (10) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rexp = 16'(ra) * 16'(rb);
         do_op(ra, rb, rexp, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_russian_peasant_modified_umul_8
